// File: rtl/selector_pulse_scheduler.sv
// Shared output scheduler for the mode/light selector lines: queues debounced events per
// channel and emits fixed-width active-low pulses, round-robin arbitrated, with a minimum gap.
module selector_pulse_scheduler #(
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned STARTUP_CYCLES = 16,
    parameter int unsigned PEND_MAX       = 3,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mode_req,
    input  logic       light_req,
    output logic       mode_selector_out,
    output logic       light_selector_out,
    output logic       busy,
    output logic [1:0] mode_pending,
    output logic [1:0] light_pending,
    output logic       overflow
);

    typedef enum logic [1:0] {StStartup, StIdle, StPulse, StGap} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_light_q;
    logic             mode_sel_q, light_sel_q, overflow_q;
    logic [1:0]       mode_pend_q, light_pend_q;
    logic [1:0]       mode_pend_d, light_pend_d;
    logic             grant_slot, grant_mode, grant_light;
    logic             mode_drop, light_drop;

    always_comb begin
        grant_slot  = (state_q == StIdle) ||
                      (state_q == StGap && cnt_q == CNT_W'(GAP_CYCLES - 1));
        // Mode wins a collision unless it was granted last.
        grant_mode  = grant_slot && (mode_pend_q != 2'd0) &&
                      ((light_pend_q == 2'd0) || last_light_q);
        grant_light = grant_slot && (light_pend_q != 2'd0) && !grant_mode;

        mode_drop   = mode_req && !grant_mode && (mode_pend_q == 2'(PEND_MAX));
        light_drop  = light_req && !grant_light && (light_pend_q == 2'(PEND_MAX));

        mode_pend_d = mode_pend_q;
        if (mode_req && !grant_mode && !mode_drop) begin
            mode_pend_d = mode_pend_q + 2'd1;
        end else if (grant_mode && !mode_req) begin
            mode_pend_d = mode_pend_q - 2'd1;
        end

        light_pend_d = light_pend_q;
        if (light_req && !grant_light && !light_drop) begin
            light_pend_d = light_pend_q + 2'd1;
        end else if (grant_light && !light_req) begin
            light_pend_d = light_pend_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StStartup;
            cnt_q        <= '0;
            last_light_q <= 1'b1;
            mode_sel_q   <= 1'b1;
            light_sel_q  <= 1'b1;
            overflow_q   <= 1'b0;
            mode_pend_q  <= 2'd0;
            light_pend_q <= 2'd0;
        end else begin
            mode_pend_q  <= mode_pend_d;
            light_pend_q <= light_pend_d;
            overflow_q   <= mode_drop || light_drop;
            if (grant_mode || grant_light) begin
                state_q      <= StPulse;
                cnt_q        <= '0;
                last_light_q <= grant_light;
                mode_sel_q   <= !grant_mode;
                light_sel_q  <= !grant_light;
            end else begin
                case (state_q)
                    StStartup: begin
                        if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StIdle: cnt_q <= '0;
                    StPulse: begin
                        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                            state_q     <= StGap;
                            cnt_q       <= '0;
                            mode_sel_q  <= 1'b1;
                            light_sel_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StGap: begin
                        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StStartup;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign mode_selector_out  = mode_sel_q;
    assign light_selector_out = light_sel_q;
    assign busy               = (state_q != StIdle);
    assign mode_pending       = mode_pend_q;
    assign light_pending      = light_pend_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_selector_pulse_scheduler.sv
// Directed bench for selector_pulse_scheduler: per-cycle vector table plus hand-written
// sequences for saturation, reset mid-pulse and round-robin alternation.
module tb_selector_pulse_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       mode_req = 1'b0;
    logic       light_req = 1'b0;
    logic       mode_sel, light_sel, busy, overflow;
    logic [1:0] mode_pending, light_pending;

    int errors = 0;
    int checks = 0;

    selector_pulse_scheduler dut (
        .clk                (clk),
        .resetn             (resetn),
        .mode_req           (mode_req),
        .light_req          (light_req),
        .mode_selector_out  (mode_sel),
        .light_selector_out (light_sel),
        .busy               (busy),
        .mode_pending       (mode_pending),
        .light_pending      (light_pending),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       mreq, lreq;
        logic       em, el, eb;
        logic [1:0] emp, elp;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input int n, input logic m, input logic l, input logic em,
                       input logic el, input logic eb, input logic [1:0] emp,
                       input logic [1:0] elp, input logic eo);
        vec_t v;
        v.n = n; v.mreq = m; v.lreq = l; v.em = em; v.el = el; v.eb = eb;
        v.emp = emp; v.elp = elp; v.eo = eo;
        tbl.push_back(v);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step(input logic m, input logic l);
        mode_req  = m;
        light_req = l;
        @(posedge clk);
        #1;
        mode_req  = 1'b0;
        light_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn) chk("never_both_low", {31'd0, !(mode_sel == 1'b0 && light_sel == 1'b0)}, 1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         e, n, starts[$];
        logic       pm, pl;
        int         order[$];
        logic [1:0] exp_mp;

        // Reset release, then first collision (mode wins), then single mode request.
        add(15, 0, 0, 1, 1, 1, 0, 0, 0);
        add(1,  0, 0, 1, 1, 0, 0, 0, 0);
        add(2,  0, 0, 1, 1, 0, 0, 0, 0);
        add(1,  1, 1, 1, 1, 0, 1, 1, 0);
        add(8,  0, 0, 0, 1, 1, 0, 1, 0);
        add(4,  0, 0, 1, 1, 1, 0, 1, 0);
        add(8,  0, 0, 1, 0, 1, 0, 0, 0);
        add(4,  0, 0, 1, 1, 1, 0, 0, 0);
        add(2,  0, 0, 1, 1, 0, 0, 0, 0);
        add(1,  1, 0, 1, 1, 0, 1, 0, 0);
        add(8,  0, 0, 0, 1, 1, 0, 0, 0);
        add(4,  0, 0, 1, 1, 1, 0, 0, 0);
        add(2,  0, 0, 1, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst mode_sel", {31'd0, mode_sel}, 1);
        chk("rst light_sel", {31'd0, light_sel}, 1);
        chk("rst busy", {31'd0, busy}, 1);
        chk("rst mode_pending", {30'd0, mode_pending}, 0);
        chk("rst light_pending", {30'd0, light_pending}, 0);
        chk("rst overflow", {31'd0, overflow}, 0);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(k == 0 ? tbl[i].mreq : 1'b0, k == 0 ? tbl[i].lreq : 1'b0);
                chk($sformatf("v%0d.%0d mode_sel", i, k), {31'd0, mode_sel}, {31'd0, tbl[i].em});
                chk($sformatf("v%0d.%0d light_sel", i, k), {31'd0, light_sel}, {31'd0, tbl[i].el});
                chk($sformatf("v%0d.%0d busy", i, k), {31'd0, busy}, {31'd0, tbl[i].eb});
                chk($sformatf("v%0d.%0d mode_pend", i, k), {30'd0, mode_pending},
                    {30'd0, tbl[i].emp});
                chk($sformatf("v%0d.%0d light_pend", i, k), {30'd0, light_pending},
                    {30'd0, tbl[i].elp});
                chk($sformatf("v%0d.%0d overflow", i, k), {31'd0, overflow}, {31'd0, tbl[i].eo});
            end
        end

        // Saturation during STARTUP: 5 mode requests two cycles apart.
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        pm = 1'b1;
        for (e = 1; e <= 80; e++) begin
            step(e <= 9 && (e % 2) == 1, 1'b0);
            if (e <= 10) begin
                exp_mp = (e >= 5) ? 2'd3 : 2'((e + 1) / 2);
                chk($sformatf("sat e%0d mode_pend", e), {30'd0, mode_pending}, {30'd0, exp_mp});
                chk($sformatf("sat e%0d overflow", e), {31'd0, overflow},
                    {31'd0, (e == 7 || e == 9)});
            end
            if (pm && !mode_sel) starts.push_back(e);
            pm = mode_sel;
        end
        chk("sat pulse_count", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("sat first_start", starts[0], 17);
            chk("sat spacing1", starts[1] - starts[0], 12);
            chk("sat spacing2", starts[2] - starts[1], 12);
        end

        // Reset asserted on the third low cycle of a light pulse.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rmid light_low", {31'd0, light_sel}, 0);
        chk("rmid light_pend", {30'd0, light_pending}, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rmid light_sel", {31'd0, light_sel}, 1);
        chk("rmid light_pend0", {30'd0, light_pending}, 0);
        chk("rmid mode_pend0", {30'd0, mode_pending}, 0);
        chk("rmid busy", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!light_sel || !mode_sel) chk("rmid startup_quiet", n, 0);
        end
        chk("rmid startup_len", n, 16);

        // Both channels queued: grants must alternate mode, light, mode, light...
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        pm = mode_sel;
        pl = light_sel;
        if (!mode_sel) order.push_back(0);
        for (int c = 0; c < 150; c++) begin
            step(1'b0, 1'b0);
            if (pm && !mode_sel) order.push_back(0);
            if (pl && !light_sel) order.push_back(1);
            pm = mode_sel;
            pl = light_sel;
        end
        chk("alt grant_count", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++) begin
            chk($sformatf("alt grant%0d", i), order[i], i % 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/selector_pulse_scheduler.md
# selector_pulse_scheduler

Sequences button events from the two debounced selector channels (mode, light) onto the cube-controller selector lines. It queues requests per channel and emits fixed-width active-low pulses, never both lines at once. Collisions are arbitrated round-robin, and a minimum gap is enforced between pulses. It sits between the debouncer outputs and the mode_selector_out / light_selector_out pins of the CPLD, and replaces ad-hoc per-channel delaying with one shared output scheduler.

## Interface
- PULSE_CYCLES, 8: width of each output pulse in clk cycles (≥1)
- GAP_CYCLES, 4: minimum high time between any two pulses, either channel (≥1)
- STARTUP_CYCLES, 16: hold-off after reset release before the first pulse (≥1)
- PEND_MAX, 3: per-channel pending-request saturation limit (1..3)
- CNT_W, 8: width of the shared timing counter; must hold max(PULSE_CYCLES, GAP_CYCLES, STARTUP_CYCLES)

- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mode_req  in  1  debounced mode event, one-cycle-high pulse
- light_req  in  1  debounced light event, one-cycle-high pulse
- mode_selector_out  out  1  active-low mode pulse to cube
- light_selector_out  out  1  active-low light pulse to cube
- busy  out  1  high in any state other than IDLE
- mode_pending  out  2  queued mode requests
- light_pending  out  2  queued light requests
- overflow  out  1  one-cycle pulse when a request is dropped at saturation

## Operation
- Reset values: both selector outputs 1, busy 1, pending counts 0, overflow 0, state STARTUP, counter 0, last_grant = light, so mode wins the first collision.
- Pending counters:
  - A request increments its channel's counter.
  - A grant decrements the granted counter.
  - Request and grant in the same cycle on the same channel: net unchanged.
  - Request when the counter equals PEND_MAX and no same-channel grant that cycle: dropped, overflow = 1 for that cycle.
  - Both channels saturating in the same cycle: a single overflow pulse.
- Requests are accepted in every state, including STARTUP.
- FSM states:
  - STARTUP: counts STARTUP_CYCLES cycles, then goes to IDLE.
  - IDLE: if any counter > 0, grant and go to PULSE.
  - PULSE: the granted line is low for PULSE_CYCLES cycles, then go to GAP.
  - GAP: both lines high for GAP_CYCLES cycles. On the last GAP cycle, if any counter > 0, grant and go to PULSE; else go to IDLE.
- Grant:
  - Only one channel pending: that channel wins.
  - Both pending: the channel ≠ last_grant wins.
  - last_grant updates on each grant.
- Invariant: mode_selector_out and light_selector_out are never both 0.
- The counter reloads on every state entry. No arithmetic wraps; pending counters saturate.

## Timing
- Outputs are registered. No combinational path from req to selector outputs.
- Latency from IDLE:
  - req sampled high at edge E0 → pending = 1 after E0.
  - Grant at E1: state = PULSE, line low after E1.
  - Line high again after E1 + PULSE_CYCLES.
- Back-to-back grants: low-start to low-start = PULSE_CYCLES + GAP_CYCLES cycles.
- busy reads 0 only in IDLE. It is 1 from reset assertion until STARTUP completes.
- Reset asserted mid-pulse: line returns high immediately (async), queue is cleared, and the STARTUP hold-off reruns after release.
- Request on the cycle resetn deasserts: it is sampled only if resetn was released before that edge (standard recovery timing).

## Test plan
All scenarios use default parameters.
- Reset release, no requests → outputs stay 1; busy = 1 for 16 cycles, then 0.
- Single mode_req in IDLE at edge E0 → mode_selector_out low on cycles E1..E1+7, high from E1+8; light line stays 1 throughout; mode_pending returns to 0 after E1.
- mode_req and light_req in the same cycle from IDLE, first grant after reset → mode pulse of 8 cycles, then 4 gap cycles, then light pulse of 8 cycles; outputs are never low simultaneously.
- 5 mode_req pulses spaced 2 cycles apart during STARTUP → mode_pending saturates at 3, overflow pulses twice, and exactly 3 mode pulses appear after STARTUP, each 12 cycles apart.
- Continuous alternating requests with both channels kept pending → strict mode, light, mode, light grant order.
- resetn driven low at cycle 3 of a light pulse → light_selector_out = 1 in the same cycle, both pending counts 0, and STARTUP hold-off of 16 cycles after release.
